// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared defaults, state encoding and index-width helper for the shuffle buffer
// Ports: none (package).
package esm_pkg;

  localparam int BS_DEFAULT = 16;
  localparam int DW_DEFAULT = 8;

  // Index width for a slot count; the external selector uses the same rule.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(BS_DEFAULT);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/free_slot_encoder.sv
// rtl/free_slot_encoder.sv - lowest-index free slot priority encoder
// Ports:
//   occupancy  [0:BS-1] in   bit i set = slot i holds data
//   free_index [IW-1:0] out  lowest index whose occupancy bit is 0 (0 when none free)
//   any_free            out  at least one slot is free
module free_slot_encoder
  import esm_pkg::*;
#(
  parameter int BS = BS_DEFAULT,
  parameter int IW = IDX_W
) (
  input  logic [0:BS-1] occupancy,
  output logic [IW-1:0] free_index,
  output logic          any_free
);

  // Scan from the top down so the lowest free index is written last and wins.
  always_comb begin
    free_index = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!occupancy[i]) free_index = IW'(i);
    end
  end

  assign any_free = ~&occupancy;

endmodule

// File: rtl/shuffle_buffer.sv
// rtl/shuffle_buffer.sv - slot buffer emitting words in an order chosen by an external random selector
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        producer handshake; in_data word, in_last ends a burst
//   candidate_list [0:BS-1]  registered occupancy bitmap fed to the selector
//   sel_index, sel_valid     slot picked by the selector
//   out_valid/out_ready      consumer handshake; out_data word from slot sel_index
//   occ_count                number of occupied slots
//   sel_err                  sticky: selector named an empty slot while emitting
module shuffle_buffer
  import esm_pkg::*;
#(
  parameter int BS = BS_DEFAULT,
  parameter int DW = DW_DEFAULT,
  localparam int IW = idx_width(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic [0:BS-1] candidate_list,
  input  logic [IW-1:0] sel_index,
  input  logic          sel_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW:0]   occ_count,
  output logic          sel_err
);

  state_t        state, state_nxt;
  logic [0:BS-1] occupancy;
  logic [IW:0]   occ_cnt;
  logic          drain;
  logic          sel_err_q;
  logic [DW-1:0] slot_mem [BS];

  logic [IW-1:0] free_index;
  logic          any_free;
  logic          last_free;
  logic          wr_en, rd_en, drain_set, drain_clr, err_set;

  free_slot_encoder #(.BS(BS), .IW(IW)) u_free_enc (
    .occupancy  (occupancy),
    .free_index (free_index),
    .any_free   (any_free)
  );

  // A write while exactly one slot is free fills the buffer.
  assign last_free = (occ_cnt == (IW+1)'(BS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    drain_set = 1'b0;
    drain_clr = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      ST_FILL: begin
        in_ready = any_free;
        if (in_valid && any_free) begin
          wr_en = 1'b1;
          if (in_last) drain_set = 1'b1;
          if (in_last || last_free) state_nxt = ST_SETTLE;
        end
      end
      // One dead cycle lets the selector register the updated candidate_list.
      ST_SETTLE: begin
        if (occ_cnt != '0) begin
          state_nxt = ST_EMIT;
        end else begin
          state_nxt = ST_FILL;
          drain_clr = 1'b1;
        end
      end
      ST_EMIT: begin
        out_data = slot_mem[sel_index];
        if (sel_valid) begin
          if (occupancy[sel_index]) out_valid = 1'b1;
          else                      err_set   = 1'b1;
        end
        if (out_valid && out_ready) begin
          rd_en     = 1'b1;
          state_nxt = drain ? ST_SETTLE : ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Writes only happen in FILL and reads only in EMIT, so the two never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      occ_cnt   <= '0;
      drain     <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        occupancy[free_index] <= 1'b1;
        occ_cnt               <= occ_cnt + (IW+1)'(1);
      end else if (rd_en) begin
        occupancy[sel_index]  <= 1'b0;
        occ_cnt               <= occ_cnt - (IW+1)'(1);
      end
      if (drain_set)      drain <= 1'b1;
      else if (drain_clr) drain <= 1'b0;
      if (err_set) sel_err_q <= 1'b1;
    end
  end

  // Slot contents are meaningful only where occupancy is set, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) slot_mem[free_index] <= in_data;
  end

  assign candidate_list = occupancy;
  assign occ_count      = occ_cnt;
  assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_shuffle_buffer.sv
// tb/tb_shuffle_buffer.sv - self-checking bench for shuffle_buffer
module tb_shuffle_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [0:15] candidate_list;
  logic [3:0]  sel_index;
  logic        sel_valid;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [4:0]  occ_count;
  logic        sel_err;

  logic [15:0] cand;
  assign cand = candidate_list;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shuffle_buffer #(.BS(16), .DW(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .candidate_list (candidate_list),
    .sel_index      (sel_index),
    .sel_valid      (sel_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .occ_count      (occ_count),
    .sel_err        (sel_err)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        il;
    logic        sv;
    logic [3:0]  si;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    int          e_od;
    logic [4:0]  e_occ;
    logic [15:0] e_cand;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [7:0] id, input logic il,
                              input logic sv, input logic [3:0] si, input logic ordy,
                              input logic e_ir, input logic e_ov, input int e_od,
                              input logic [4:0] e_occ, input logic [15:0] e_cand,
                              input logic e_err);
    vec_t v;
    v.iv = iv; v.id = id; v.il = il; v.sv = sv; v.si = si; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    v.e_cand = e_cand; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  // Slots 0..n-1 occupied; slot 0 is the leftmost bit.
  function automatic logic [15:0] top_bits(input int n);
    logic [15:0] m;
    m = '0;
    for (int j = 0; j < n; j++) m[15-j] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    sel_valid = 1'b0; sel_index = '0; out_ready = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      in_valid  = vecs[k].iv;
      in_data   = vecs[k].id;
      in_last   = vecs[k].il;
      sel_valid = vecs[k].sv;
      sel_index = vecs[k].si;
      out_ready = vecs[k].ordy;
      #2;
      check({tag, " in_ready"},  k, 32'(in_ready),  32'(vecs[k].e_ir));
      check({tag, " out_valid"}, k, 32'(out_valid), 32'(vecs[k].e_ov));
      if (vecs[k].e_od >= 0) check({tag, " out_data"}, k, 32'(out_data), vecs[k].e_od);
      check({tag, " occ_count"}, k, 32'(occ_count), 32'(vecs[k].e_occ));
      check({tag, " cand_list"}, k, 32'(cand),      32'(vecs[k].e_cand));
      check({tag, " sel_err"},   k, 32'(sel_err),   32'(vecs[k].e_err));
    end
    vecs.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " occ_count"}, 0, 32'(occ_count), 32'd0);
    check({tag, " cand_list"}, 0, 32'(cand),      32'd0);
    check({tag, " in_ready"},  0, 32'(in_ready),  32'd1);
    check({tag, " out_valid"}, 0, 32'(out_valid), 32'd0);
    check({tag, " out_data"},  0, 32'(out_data),  32'd0);
    check({tag, " sel_err"},   0, 32'(sel_err),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #2;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Fill, emit slot 5, refill slot 5, hold, emit slot 3, drain with a bad pick.
    for (int i = 0; i < 16; i++)
      add(1, 8'(8'h10 + i), 0, 0, 0, 0,  1, 0, -1, 5'(i), top_bits(i), 0);
    add(1, 8'hAA, 0, 0, 0, 0,  0, 0, -1,     16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 0, 0, 0,  0, 0, -1,     16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 0, 0, 1,  0, 0, -1,     16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 1, 5, 1,  0, 1, 'h15,   16, 16'hFFFF, 0);
    add(1, 8'h55, 0, 0, 0, 0,  1, 0, -1,     15, 16'hFBFF, 0);
    add(0, 8'h00, 0, 0, 0, 0,  0, 0, -1,     16, 16'hFFFF, 0);
    for (int i = 0; i < 4; i++)
      add(0, 8'h00, 0, 1, 5, 0,  0, 1, 'h55, 16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 1, 3, 1,  0, 1, 'h13,   16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 0, 0, 0,  1, 0, -1,     15, 16'hEFFF, 0);
    add(0, 8'h00, 0, 0, 0, 0,  1, 0, -1,     15, 16'hEFFF, 0);
    add(1, 8'h33, 1, 0, 0, 0,  1, 0, -1,     15, 16'hEFFF, 0);
    add(0, 8'h00, 0, 0, 0, 0,  0, 0, -1,     16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 1, 7, 1,  0, 1, 'h17,   16, 16'hFFFF, 0);
    add(0, 8'h00, 0, 1, 7, 1,  0, 0, -1,     15, 16'hFEFF, 0);
    add(0, 8'h00, 0, 1, 7, 1,  0, 0, -1,     15, 16'hFEFF, 0);
    add(0, 8'h00, 0, 1, 7, 1,  0, 0, -1,     15, 16'hFEFF, 1);
    add(0, 8'h00, 0, 1, 2, 0,  0, 1, 'h12,   15, 16'hFEFF, 1);
    run_table("full");

    // Reset clears the sticky error.
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_state("err_rst");

    // Three-word burst drained in order 2,0,1, then normal acceptance resumes.
    add(1, 8'hA0, 0, 0, 0, 0,  1, 0, -1,    0, 16'h0000, 0);
    add(1, 8'hA1, 0, 0, 0, 0,  1, 0, -1,    1, 16'h8000, 0);
    add(1, 8'hA2, 1, 0, 0, 0,  1, 0, -1,    2, 16'hC000, 0);
    add(0, 8'h00, 0, 0, 0, 0,  0, 0, -1,    3, 16'hE000, 0);
    add(0, 8'h00, 0, 1, 2, 1,  0, 1, 'hA2,  3, 16'hE000, 0);
    add(0, 8'h00, 0, 1, 0, 1,  0, 0, -1,    2, 16'hC000, 0);
    add(0, 8'h00, 0, 1, 0, 1,  0, 1, 'hA0,  2, 16'hC000, 0);
    add(0, 8'h00, 0, 1, 1, 1,  0, 0, -1,    1, 16'h4000, 0);
    add(0, 8'h00, 0, 1, 1, 1,  0, 1, 'hA1,  1, 16'h4000, 0);
    add(0, 8'h00, 0, 0, 0, 0,  0, 0, -1,    0, 16'h0000, 0);
    add(1, 8'hB0, 0, 0, 0, 0,  1, 0, -1,    0, 16'h0000, 0);
    add(0, 8'h00, 0, 0, 0, 0,  1, 0, -1,    1, 16'h8000, 0);
    run_table("drain");

    // Six more words for seven occupied slots, then an asynchronous reset.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + i);
    end
    @(negedge clk);
    drive_idle();
    #2;
    check("seven occ_count", 0, 32'(occ_count), 32'd7);
    check("seven cand_list", 0, 32'(cand),      32'hFE00);
    rst = 1'b1;
    #1;
    check("async occ_count", 0, 32'(occ_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_state("mid_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shuffle_buffer.md
SHUFFLE_BUFFER -- requirements
Module: shuffle_buffer

Interface
REQ-001 Parameter BS, 16, number of buffer slots; power of two, at least 2.
REQ-002 Parameter DW, 8, data word width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer offers in_data/in_last.
REQ-006 in_ready  output  1  buffer accepts the offered word this cycle.
REQ-007 in_data  input  DW  word to store.
REQ-008 in_last  input  1  final word of a burst; triggers drain after acceptance.
REQ-009 candidate_list  output  BS  registered occupancy bitmap, bit i = slot i holds valid data; bit 0 at MSB position (index 0 leftmost), matching the selector's [0:BS-1] ordering.
REQ-010 sel_index  input  clog2(BS)  slot chosen by the external random selector.
REQ-011 sel_valid  input  1  selector has at least one candidate (sel_index meaningful).
REQ-012 out_valid  output  1  out_data is presented.
REQ-013 out_ready  input  1  consumer accepts out_data.
REQ-014 out_data  output  DW  word read from slot sel_index.
REQ-015 occ_count  output  clog2(BS)+1  number of occupied slots.
REQ-016 sel_err  output  1  sticky: selector named an empty slot.

Function
REQ-017 States FILL, SETTLE, EMIT; the SETTLE state exists because the selector registers its table one cycle after candidate_list changes.
REQ-018 FILL: in_ready = 1 iff at least one slot is free; on in_valid&&in_ready, write in_data to the lowest-index free slot and set its occupancy bit.
REQ-019 FILL -> SETTLE when the accepting write fills the last free slot, or when in_last is accepted (set drain flag); otherwise stay in FILL.
REQ-020 SETTLE: exactly one cycle; in_ready = 0; out_valid = 0; then -> EMIT if occ_count != 0, else -> FILL with the drain flag cleared.
REQ-021 EMIT: in_ready = 0; out_valid = sel_valid && occupancy[sel_index]; out_data = slot[sel_index] (combinational).
REQ-022 EMIT, on out_valid&&out_ready: clear occupancy[sel_index]; next state SETTLE if the drain flag is set, else FILL.
REQ-023 EMIT with no handshake: hold state; out_valid/out_data may change only if sel_index changes.
REQ-024 EMIT with sel_valid=1 and occupancy[sel_index]=0: set sel_err, out_valid=0, hold state.
REQ-025 occ_count = popcount(occupancy), registered; it changes by exactly +1 per accepted write and −1 per emitted word, and never wraps.
REQ-026 candidate_list equals the registered occupancy vector; it is not updated in the same cycle as the write or read.
REQ-027 Simultaneous in and out transfers are impossible by construction (in_ready=0 outside FILL).
REQ-028 Steady state: after the first full fill, each emission frees one slot; the next accepted word refills it; order of emitted words is decided solely by sel_index.
REQ-029 Drain: after in_last, the FILL/SETTLE/EMIT loop continues, writing no words, until occ_count = 0, then FILL resumes normal acceptance.

Reset
REQ-030 On rst: state FILL, occupancy all 0, occ_count 0, drain flag 0, sel_err 0, in_ready 1, out_valid 0, out_data 0.
REQ-031 Slot data storage is not reset.
REQ-032 rst asserted mid-burst discards all stored words; no output handshake completes in the reset cycle.

Structure
REQ-033 Shared package esm_pkg holds the BS and DW defaults, the state enumeration, and an index-width constant shared with the selector.
REQ-034 Sub-module free_slot_encoder: combinational lowest-index-zero priority encoder over occupancy, outputs index plus an any_free flag.
REQ-035 Slot storage is a plain register array; no RAM macro.

Verification
REQ-036 Reset, then write 16 words 0x10..0x1F with sel_valid=0 -> slots 0..15 filled in order; candidate_list=all ones; occ_count=16; in_ready=0; state SETTLE for 1 cycle, then EMIT.
REQ-037 Full buffer, sel_index=5, out_ready=1 -> out_data=0x15, bit 5 cleared next cycle, occ_count=15; the next write lands in slot 5.
REQ-038 Write 3 words with in_last on the 3rd, then sel_index sequence 2,0,1 -> outputs in that order, each separated by SETTLE, then occ_count=0 and back in FILL.
REQ-039 EMIT with out_ready=0 for 4 cycles -> out_valid held, occupancy unchanged; on out_ready=1 exactly one word is emitted.
REQ-040 EMIT with sel_index pointing to an empty slot -> sel_err=1 (sticky), out_valid=0, no state change; clears only on rst.
REQ-041 Assert rst while 7 slots are occupied -> next cycle occ_count=0, candidate_list=0, in_ready=1, out_valid=0.
